peripheral_msi_slave_arbiter_apb4: RTL
======================================

# peripheral_msi_slave_arbiter_apb4

Per-slave bus arbiter for the MSI interconnect. It collects connection requests from every master port that decodes an access to this slave and grants the slave to exactly one master at a time. The winner has the highest priority, with round-robin among masters of equal priority. It changes ownership only at master-indicated switch points, and drives the `master_granted` bit each master port samples for this slave.

## Interface
Parameters:
- `MASTERS`, 5: number of master ports competing for this slave
- `MASTER_BITS`, `max(1,$clog2(MASTERS))`: width of the granted index (localparam)

Ports:
- `HCLK`  in  1  bus clock; all state updates on rising edge
- `HRESET`  in  1  asynchronous, active-high reset
- `mst_req`  in  `MASTERS`  bit m = master port m's `slvHSEL` bit for this slave
- `mst_priority`  in  `MASTERS`x3  per-master priority; 7 highest, 0 lowest
- `can_switch`  in  `MASTERS`  bit m high = master m is at a point where it may release the slave
- `slv_HREADY`  in  1  this slave's HREADYOUT
- `master_granted`  out  `MASTERS`  one-hot (or zero) grant; bit m goes to master port m
- `granted_id`  out  `MASTER_BITS`  binary index of current owner; holds last owner when idle
- `bus_busy`  out  1  high while any master owns the slave

## Operation
- FSM with two states:
  - IDLE: no owner, `master_granted`=0, `bus_busy`=0.
  - OWNED: exactly one `master_granted` bit set, `bus_busy`=1.
- Winner (combinational):
  - Among m with `mst_req[m]`=1, select the maximum `mst_priority[m]`.
  - Ties are resolved by search order `rr_ptr+1, rr_ptr+2, …` modulo `MASTERS`; the first tied master in that order wins.
- IDLE:
  - Any `mst_req` set: register the winner into `master_granted`/`granted_id`, set `rr_ptr` to the winner, go to OWNED.
  - No requests: stay in IDLE. There is no parking.
- OWNED, owner o:
  - Arbitrate only when `switch_ok` = `can_switch[o] & slv_HREADY`.
  - `switch_ok`=0: keep the grant unchanged, whatever other requests or priorities exist.
  - `switch_ok`=1 and any `mst_req` set: re-arbitrate, register the winner, and update `rr_ptr`. The winner may be o again if o is still the unique best candidate.
  - `switch_ok`=1 and no `mst_req` set: clear the grant and go to IDLE. `granted_id` holds its value.
- `rr_ptr` (`MASTER_BITS` wide) changes only on a registered grant. It wraps from `MASTERS-1` to 0.
- `can_switch`/`mst_priority` of non-owners are ignored except for `mst_priority` in arbitration.
- `MASTERS`=1: master 0 is granted whenever it requests; the round-robin logic degenerates to a constant.

## Timing
- Reset (asynchronous, immediate, including mid-ownership):
  - `master_granted`=0, `granted_id`=0, `bus_busy`=0
  - FSM=IDLE
  - `rr_ptr`=`MASTERS-1`, so master 0 wins the first tie
- Grant latency: a request sampled at edge k gives `master_granted` valid after edge k (one cycle). Master ports hold the request in their pending state until then.
- Switch latency: `switch_ok` and a new winner sampled at edge k gives the new owner's bit after edge k. The old and new grant bits never overlap; the one-hot change is atomic.
- Release: owner request low with `switch_ok`=1 at edge k gives all-zero grant after edge k. A request arriving in that same cycle is granted at edge k instead (no idle bubble).
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Reset: assert `HRESET` during an active grant to master 3 -> `master_granted`=0, `bus_busy`=0, `granted_id`=0 immediately, before the next `HCLK` edge.
- Single request: `mst_req`=5'b00100, priority 3 -> one cycle later `master_granted`=5'b00100, `granted_id`=2, `bus_busy`=1.
- Priority: m1 at prio 2 and m3 at prio 6 request together from IDLE -> `master_granted`=5'b01000. After m3 releases with `can_switch`=1 and `slv_HREADY`=1 -> 5'b00010.
- Round-robin: m0 and m4 at prio 1 request continuously, `can_switch`=all-ones, `slv_HREADY`=1 -> grants per cycle 0,4,0,4…, first grant to 0.
- Hold rules, with m1 owner and m2 requesting at prio 7:
  - `can_switch[1]`=0 -> m1 held.
  - `can_switch[1]`=1, `slv_HREADY`=0 -> m1 held.
  - Both 1 -> `master_granted`=5'b00100 next cycle, never two bits set.
- Release and back-to-back: owner m0 drops its request with `switch_ok`=1 and no others -> grant 0 and `bus_busy`=0 next cycle. Repeat with m2 requesting in the same cycle -> grant goes directly to m2 with no idle cycle.

Source files
------------

// File: rtl/peripheral_msi_slave_arbiter_apb4.sv
// ---------------------------------------------------------------------------
// peripheral_msi_slave_arbiter_apb4
//
// Per-slave arbiter for the MSI interconnect. Every master port that decodes
// an access to this slave raises its request bit. The arbiter grants the
// slave to one master at a time. The highest priority wins. Ties between
// masters of equal priority are broken round-robin. Ownership changes only
// when the current owner signals a switch point and the slave is ready.
//
// Ports:
//   HCLK           bus clock, all state changes on the rising edge
//   HRESET         asynchronous, active-high reset
//   mst_req        per-master request (the slvHSEL bit for this slave)
//   mst_priority   per-master 3-bit priority, 7 highest
//   can_switch     per-master "may release the slave now" flag
//   slv_HREADY     HREADYOUT of this slave
//   master_granted one-hot (or zero) grant, bit m to master port m
//   granted_id     binary index of the owner; holds the last owner when idle
//   bus_busy       high while a master owns the slave
// ---------------------------------------------------------------------------
module peripheral_msi_slave_arbiter_apb4 #(
    parameter int MASTERS = 5,
    localparam int MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic [MASTERS-1:0]         mst_req,
    input  logic [MASTERS-1:0][2:0]    mst_priority,
    input  logic [MASTERS-1:0]         can_switch,
    input  logic                       slv_HREADY,
    output logic [MASTERS-1:0]         master_granted,
    output logic [MASTER_BITS-1:0]     granted_id,
    output logic                       bus_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t                   state_reg;
    state_t                   state_next;
    logic [MASTERS-1:0]       grant_reg;
    logic [MASTERS-1:0]       grant_next;
    logic [MASTER_BITS-1:0]   id_reg;
    logic [MASTER_BITS-1:0]   id_next;
    logic [MASTER_BITS-1:0]   rr_ptr_reg;
    logic [MASTER_BITS-1:0]   rr_ptr_next;

    // Arbitration intermediates
    logic [2:0]               max_prio;
    logic [MASTERS-1:0]       cand;
    logic [MASTERS-1:0]       win_onehot;
    logic [MASTER_BITS-1:0]   winner;
    logic                     any_req;
    logic                     switch_ok;

    assign any_req = |mst_req;

    // The owner's switch flag is picked with the grant vector instead of an
    // index, so the non-owners' can_switch bits cannot affect the result.
    assign switch_ok = (|(can_switch & grant_reg)) & slv_HREADY;

    // Highest priority among the current requesters.
    always_comb begin
        max_prio = 3'd0;
        for (int m = 0; m < MASTERS; m++) begin
            if (mst_req[m] && (mst_priority[m] > max_prio)) begin
                max_prio = mst_priority[m];
            end
        end
    end

    // A candidate is a requester that sits at the maximum priority.
    generate
        for (genvar gi = 0; gi < MASTERS; gi++) begin : g_cand
            assign cand[gi] = mst_req[gi] && (mst_priority[gi] == max_prio);
        end
    endgenerate

    // Round-robin pick among the candidates. The search starts just after
    // rr_ptr and ends at rr_ptr itself, so the previous winner loses any tie
    // with another candidate but can still win when it is the only one.
    // rr_ptr < MASTERS and the offset is at most MASTERS, so one conditional
    // subtraction is enough to wrap.
    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        for (int i = 1; i <= MASTERS; i++) begin
            idx = int'(rr_ptr_reg) + i;
            if (idx >= MASTERS) begin
                idx = idx - MASTERS;
            end
            if (!found && cand[idx]) begin
                winner = MASTER_BITS'(idx);
                found  = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < MASTERS; gi++) begin : g_onehot
            assign win_onehot[gi] = (winner == MASTER_BITS'(gi));
        end
    endgenerate

    // Next-state and next-output logic.
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        id_next     = id_reg;
        rr_ptr_next = rr_ptr_reg;
        unique case (state_reg)
            IDLE: begin
                if (any_req) begin
                    grant_next  = win_onehot;
                    id_next     = winner;
                    rr_ptr_next = winner;
                    state_next  = OWNED;
                end
            end
            OWNED: begin
                if (switch_ok) begin
                    if (any_req) begin
                        // Direct handover: the grant vector is replaced in a
                        // single edge, so old and new bits never overlap.
                        grant_next  = win_onehot;
                        id_next     = winner;
                        rr_ptr_next = winner;
                    end else begin
                        // Release; the last owner's index stays visible.
                        grant_next = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            id_reg     <= '0;
            // Pointer at the last master makes master 0 win the first tie.
            rr_ptr_reg <= MASTER_BITS'(MASTERS - 1);
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            id_reg     <= id_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    assign master_granted = grant_reg;
    assign granted_id     = id_reg;
    assign bus_busy       = (state_reg == OWNED);

endmodule
